// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared FSM state and frame constants for the UART debug bridge
`timescale 1ns/1ps
package uart_dbg_pkg;
  typedef enum logic [1:0] {S_RX, S_ISSUE, S_TX} state_t;
  localparam int FRAME_BYTES = 9;
  localparam int RESP_BYTES = 4;
  localparam logic [7:0] DBG_NOP = 8'h00;
endpackage

// File: rtl/uart_dbg_rx.sv
// uart_dbg_rx: 8N1 deserializer with synchronizer, start-glitch rejection and stop check
`timescale 1ns/1ps
module uart_dbg_rx #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [1:0] sync;
  logic rx, rx_d, active, tick;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [7:0] sh;
  assign rx = sync[1];
  // idx 0 is the start bit, sampled half a bit in; 1..8 data; 9 stop
  assign tick = cnt == (idx == 4'd0 ? CW'(CLK_DIV/2-1) : CW'(CLK_DIV-1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
      active <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      byte_o <= '0;
      valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      sync <= {sync[0], rx_i};
      rx_d <= rx;
      valid_o <= 1'b0;
      err_o <= 1'b0;
      if (!active) begin
        active <= rx_d & ~rx;
        cnt <= '0;
        idx <= '0;
      end else if (tick) begin
        cnt <= '0;
        idx <= idx + 4'd1;
        if (idx == 4'd0) active <= ~rx;
        else if (idx == 4'd9) begin
          active <= 1'b0;
          valid_o <= rx;
          err_o <= ~rx;
          byte_o <= sh;
        end else sh <= {rx, sh[7:1]};
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART command frames in, debug bus handshake, 32-bit response out
`timescale 1ns/1ps
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        frame_err_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT+1);
  state_t state, nxt;
  logic [7:0] rx_byte, f_cmd;
  logic rx_valid, rx_err, last_byte, tout_hit, tx_tick, tx_done, tx_go;
  logic [3:0] cnt, tx_bit;
  logic [31:0] f_addr, f_data, resp;
  logic [TW-1:0] tout;
  logic [8:0] tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [1:0] tx_byte;
  uart_dbg_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_i(uart_rx_i),
    .byte_o(rx_byte),
    .valid_o(rx_valid),
    .err_o(rx_err)
  );
  assign last_byte = state == S_RX && rx_valid && cnt == 4'(FRAME_BYTES-1);
  assign tout_hit = state == S_RX && cnt != 4'd0 && !rx_valid && tout == TW'(TIMEOUT);
  assign tx_tick = tx_go && tx_cnt == CW'(CLK_DIV-1);
  assign tx_done = tx_tick && tx_bit == 4'd9 && tx_byte == 2'(RESP_BYTES-1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_RX;
    else state <= nxt;
  end
  always_comb begin
    nxt = (state == S_RX && last_byte && f_cmd != DBG_NOP) ? S_ISSUE :
          (state == S_ISSUE && dbg_ready_i) ? S_TX :
          (state == S_TX && tx_done) ? S_RX : state;
  end
  assign busy_o = state != S_RX;
  // frame assembly; bus outputs only load on a complete non-NOP frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      tout <= '0;
      f_cmd <= '0;
      f_addr <= '0;
      f_data <= '0;
      dbg_cmd_o <= DBG_NOP;
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= rx_err | (rx_valid & busy_o) | tout_hit;
      tout <= (rx_valid || cnt == 4'd0) ? '0 : tout + TW'(1);
      if (state == S_RX) begin
        if (rx_err || tout_hit) cnt <= '0;
        else if (rx_valid) begin
          cnt <= last_byte ? 4'd0 : cnt + 4'd1;
          if (cnt == 4'd0) f_cmd <= rx_byte;
          else if (cnt < 4'd5) f_addr <= {f_addr[23:0], rx_byte};
          else f_data <= {f_data[23:0], rx_byte};
          if (last_byte && f_cmd != DBG_NOP) begin
            dbg_cmd_o <= f_cmd;
            dbg_addr_o <= f_addr;
            dbg_data_o <= {f_data[23:0], rx_byte};
          end
        end
      end
      if (state == S_ISSUE && dbg_ready_i) dbg_cmd_o <= DBG_NOP;
    end
  end
  // response serializer: first S_TX cycle loads byte 0, later bytes follow back to back
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      uart_tx_o <= 1'b1;
      resp <= '0;
      tx_sh <= '1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
      tx_go <= 1'b0;
    end else if (state == S_ISSUE && dbg_ready_i) resp <= dbg_data_i;
    else if (state == S_TX && !tx_go) begin
      tx_go <= 1'b1;
      uart_tx_o <= 1'b0;
      tx_sh <= {1'b1, resp[31:24]};
      resp <= {resp[23:0], 8'h00};
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        if (tx_done) tx_go <= 1'b0;
        else begin
          tx_byte <= tx_byte + 2'd1;
          uart_tx_o <= 1'b0;
          tx_sh <= {1'b1, resp[31:24]};
          resp <= {resp[23:0], 8'h00};
          tx_bit <= '0;
        end
      end else begin
        uart_tx_o <= tx_sh[0];
        tx_sh <= {1'b1, tx_sh[8:1]};
        tx_bit <= tx_bit + 4'd1;
      end
    end else if (tx_go) tx_cnt <= tx_cnt + CW'(1);
  end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed self-checking bench for the UART debug bridge
`timescale 1ns/1ps
module tb_uart_dbg_bridge;
  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 200;
  localparam int BT = 10*CLK_DIV;
  logic clk_i = 1'b0, rst_i = 1'b1, uart_rx_i = 1'b1, dbg_ready_i = 1'b0;
  logic uart_tx_o, busy_o, frame_err_o;
  logic [7:0] dbg_cmd_o;
  logic [31:0] dbg_addr_o, dbg_data_o, dbg_data_i = '0;
  int checks = 0, failures = 0, cyc = 0, err_pulses = 0;
  logic [7:0] txq[$];
  int txt[$];
  uart_dbg_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .uart_rx_i(uart_rx_i),
    .uart_tx_o(uart_tx_o),
    .dbg_cmd_o(dbg_cmd_o),
    .dbg_addr_o(dbg_addr_o),
    .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i),
    .dbg_ready_i(dbg_ready_i),
    .busy_o(busy_o),
    .frame_err_o(frame_err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (frame_err_o === 1'b1) err_pulses <= err_pulses + 1;
  // host-side UART receiver: records each byte and the cycle its start bit appeared
  initial forever begin
    @(negedge clk_i);
    if (uart_tx_o === 1'b0) begin
      logic [7:0] b;
      int t;
      t = cyc;
      repeat (CLK_DIV/2-1) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk_i);
        b[i] = uart_tx_o;
      end
      repeat (CLK_DIV) @(negedge clk_i);
      txq.push_back(b);
      txt.push_back(t);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (CLK_DIV) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CLK_DIV) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (CLK_DIV) @(negedge clk_i);
    uart_rx_i = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(c, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
  endtask
  task automatic wait_cmd();
    int n = 0;
    while (dbg_cmd_o === 8'h00 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("issue_seen", 32'(n < 3000), 1);
  endtask
  task automatic pulse_ready(input logic [31:0] d, output int k);
    dbg_data_i = d;
    dbg_ready_i = 1'b1;
    @(posedge clk_i);
    #1 k = cyc;
    @(negedge clk_i);
    dbg_ready_i = 1'b0;
  endtask
  task automatic wait_tx(input int n);
    int m = 0;
    while (txq.size() < n && m < 3000) begin
      @(negedge clk_i);
      m++;
    end
    chk("tx_bytes_seen", txq.size(), n);
  endtask
  task automatic wait_idle(output int t);
    int m = 0;
    while (busy_o !== 1'b0 && m < 3000) begin
      @(negedge clk_i);
      m++;
    end
    t = cyc;
    chk("busy_released", 32'(busy_o), 0);
  endtask
  task automatic flush();
    txq.delete();
    txt.delete();
  endtask
  initial begin
    int k, e0, t_idle;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(uart_tx_o), 1);
    chk("rst_cmd", dbg_cmd_o, 0);
    chk("rst_addr", dbg_addr_o, 0);
    chk("rst_data", dbg_data_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(frame_err_o), 0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    // write frame
    send_frame(8'h02, 32'h1000_0004, 32'hDEAD_BEEF);
    wait_cmd();
    chk("wr_cmd", dbg_cmd_o, 32'h02);
    chk("wr_addr", dbg_addr_o, 32'h1000_0004);
    chk("wr_data", dbg_data_o, 32'hDEAD_BEEF);
    chk("wr_busy", 32'(busy_o), 1);
    begin
      logic stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_i);
        if (dbg_cmd_o !== 8'h02 || dbg_addr_o !== 32'h1000_0004 || dbg_data_o !== 32'hDEAD_BEEF) stable = 1'b0;
      end
      chk("wr_stable", 32'(stable), 1);
    end
    pulse_ready(32'h0, k);
    chk("wr_cmd_nop", dbg_cmd_o, 0);
    chk("wr_addr_hold", dbg_addr_o, 32'h1000_0004);
    chk("wr_data_hold", dbg_data_o, 32'hDEAD_BEEF);
    wait_tx(4);
    chk("wr_resp", {txq[0], txq[1], txq[2], txq[3]}, 32'h0);
    chk("tx_latency", txt[0], k + 1);
    wait_idle(t_idle);
    flush();
    // read frame
    send_frame(8'h01, 32'h0000_0010, 32'h0);
    wait_cmd();
    chk("rd_cmd", dbg_cmd_o, 32'h01);
    chk("rd_addr", dbg_addr_o, 32'h10);
    pulse_ready(32'h1234_5678, k);
    wait_tx(4);
    chk("rd_resp", {txq[0], txq[1], txq[2], txq[3]}, 32'h1234_5678);
    for (int i = 1; i < 4; i++) chk("rd_byte_time", txt[i] - txt[i-1], BT);
    wait_idle(t_idle);
    chk("rd_busy_fall", t_idle, txt[3] + BT);
    flush();
    // partial frame then inter-byte timeout
    e0 = err_pulses;
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    repeat (TIMEOUT + 10) @(negedge clk_i);
    chk("timeout_err", err_pulses - e0, 1);
    send_frame(8'h03, 32'hA5A5_0001, 32'h0BAD_F00D);
    wait_cmd();
    chk("to_cmd", dbg_cmd_o, 32'h03);
    chk("to_addr", dbg_addr_o, 32'hA5A5_0001);
    chk("to_data", dbg_data_o, 32'h0BAD_F00D);
    chk("to_err_once", err_pulses - e0, 1);
    pulse_ready(32'h0, k);
    wait_idle(t_idle);
    flush();
    // bad stop bit inside a frame
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    e0 = err_pulses;
    send_byte(8'h99, 1'b0);
    repeat (CLK_DIV) @(negedge clk_i);
    chk("stop_err", err_pulses - e0, 1);
    send_frame(8'h04, 32'h0000_0020, 32'h1122_3344);
    wait_cmd();
    chk("se_cmd", dbg_cmd_o, 32'h04);
    chk("se_addr", dbg_addr_o, 32'h20);
    chk("se_data", dbg_data_o, 32'h1122_3344);
    pulse_ready(32'h0, k);
    wait_idle(t_idle);
    flush();
    // bytes dropped while waiting for ready
    send_frame(8'h05, 32'h0000_0030, 32'h0000_0055);
    wait_cmd();
    e0 = err_pulses;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (4) @(negedge clk_i);
    chk("drop_errs", err_pulses - e0, 3);
    chk("drop_cmd", dbg_cmd_o, 32'h05);
    chk("drop_addr", dbg_addr_o, 32'h30);
    chk("drop_data", dbg_data_o, 32'h55);
    chk("drop_busy", 32'(busy_o), 1);
    pulse_ready(32'hCAFE_F00D, k);
    wait_tx(4);
    chk("drop_resp", {txq[0], txq[1], txq[2], txq[3]}, 32'hCAFE_F00D);
    wait_idle(t_idle);
    repeat (100) @(negedge clk_i);
    chk("drop_resp_count", txq.size(), 4);
    flush();
    // reset while a command is on the bus
    send_frame(8'h07, 32'h0000_0070, 32'h7);
    wait_cmd();
    #1 rst_i = 1'b1;
    #1 chk("async_cmd_drop", dbg_cmd_o, 0);
    chk("async_busy_drop", 32'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    // reset during the second response byte
    send_frame(8'h06, 32'h0000_0040, 32'h0);
    wait_cmd();
    pulse_ready(32'h89AB_CDEF, k);
    wait_tx(1);
    chk("rt_first_byte", txq[0], 32'h89);
    repeat (6) @(negedge clk_i);
    chk("rt_second_start", 32'(uart_tx_o), 0);
    #1 rst_i = 1'b1;
    #1 chk("rt_tx_high", 32'(uart_tx_o), 1);
    chk("rt_cmd", dbg_cmd_o, 0);
    chk("rt_busy", 32'(busy_o), 0);
    chk("rt_addr", dbg_addr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (100) @(negedge clk_i);
    flush();
    send_frame(8'h08, 32'h0000_0050, 32'h0000_0066);
    wait_cmd();
    chk("pr_cmd", dbg_cmd_o, 32'h08);
    chk("pr_addr", dbg_addr_o, 32'h50);
    chk("pr_data", dbg_data_o, 32'h66);
    pulse_ready(32'h0102_0304, k);
    wait_tx(4);
    chk("pr_resp", {txq[0], txq[1], txq[2], txq[3]}, 32'h0102_0304);
    wait_idle(t_idle);
    flush();
    // NOP frame and a short low glitch
    e0 = err_pulses;
    send_frame(8'h00, 32'h0000_0060, 32'h0000_0077);
    uart_rx_i = 1'b0;
    repeat (2) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (100) @(negedge clk_i);
    chk("nop_err", err_pulses - e0, 0);
    chk("nop_cmd", dbg_cmd_o, 0);
    chk("nop_addr", dbg_addr_o, 32'h50);
    chk("nop_busy", 32'(busy_o), 0);
    chk("nop_no_tx", txq.size(), 0);
    send_frame(8'h09, 32'h0000_0090, 32'h0000_0099);
    wait_cmd();
    chk("gl_cmd", dbg_cmd_o, 32'h09);
    chk("gl_addr", dbg_addr_o, 32'h90);
    chk("gl_data", dbg_data_o, 32'h99);
    pulse_ready(32'h0, k);
    wait_idle(t_idle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
